// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between the
// core execute stage (port 0) and the network/debug engine (port 1), with a
// one-entry response buffer and a lock that times out when the owner idles.

package definitions;
    typedef enum logic [5:0] {
        kNOP  = 6'd0,
        kADDU = 6'd1,
        kSUBU = 6'd2,
        kAND  = 6'd3,
        kOR   = 6'd4,
        kBEQZ = 6'd5,
        kBNEZ = 6'd6
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [25:0] imm;
    } instruction_s;
endpackage

module alu_arbiter
    import definitions::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [1:0]         req_lock_i,
    input  logic [31:0]        req_rd_i [0:1],
    input  logic [31:0]        req_rs_i [0:1],
    input  instruction_s       req_op_i [0:1],
    output logic [31:0]        alu_rd_o,
    output logic [31:0]        alu_rs_o,
    output instruction_s       alu_op_o,
    input  logic [31:0]        alu_result_i,
    input  logic               alu_jump_now_i,
    output logic [1:0]         resp_valid_o,
    input  logic [1:0]         resp_ready_i,
    output logic [31:0]        resp_result_o,
    output logic               resp_jump_now_o,
    output logic               locked_o,
    output logic               lock_timeout_o
);

    typedef enum logic {UNLOCKED, LOCKED} state_e;

    // Timeout fires on the idle cycle that would carry the counter to LOCK_TIMEOUT,
    // so the lock is still held that cycle and released on the following edge.
    localparam logic [7:0] LAST_IDLE = 8'(LOCK_TIMEOUT - 1);

    state_e      state;
    logic        lock_owner;
    logic        prio;
    logic        rsp_full;
    logic        rsp_owner;
    logic [31:0] rsp_result;
    logic        rsp_jump;
    logic [7:0]  idle_cnt;

    logic        grant_valid;
    logic        grant;
    logic        can_accept;
    logic        accept;
    logic        drain;
    logic        owner_idle;
    logic        timeout;

    // Grant selection: lock owner only while locked, otherwise round-robin.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (state == LOCKED) begin
            grant_valid = req_valid_i[lock_owner];
            grant       = lock_owner;
        end else if (&req_valid_i) begin
            grant_valid = 1'b1;
            grant       = prio;
        end else if (req_valid_i[0]) begin
            grant_valid = 1'b1;
            grant       = 1'b0;
        end else if (req_valid_i[1]) begin
            grant_valid = 1'b1;
            grant       = 1'b1;
        end
    end

    // Handshake, drain and timeout qualifiers; outputs held quiet during reset.
    always_comb begin
        can_accept   = !rsp_full || resp_ready_i[rsp_owner];
        accept       = grant_valid && can_accept && !reset;
        drain        = rsp_full && resp_ready_i[rsp_owner];
        owner_idle   = (state == LOCKED) && !req_valid_i[lock_owner];
        timeout      = owner_idle && (idle_cnt == LAST_IDLE) && !reset;
        req_ready_o  = '0;
        if (accept) req_ready_o[grant] = 1'b1;
        resp_valid_o = '0;
        if (rsp_full && !reset) resp_valid_o[rsp_owner] = 1'b1;
        locked_o       = (state == LOCKED) && !reset;
        lock_timeout_o = timeout;
        resp_result_o   = rsp_result;
        resp_jump_now_o = rsp_jump;
    end

    // Shared ALU operands follow the grant even when the buffer cannot accept.
    always_comb begin
        alu_rd_o = '0;
        alu_rs_o = '0;
        alu_op_o = '0;
        if (grant_valid) begin
            alu_rd_o = req_rd_i[grant];
            alu_rs_o = req_rs_i[grant];
            alu_op_o = req_op_i[grant];
        end
    end

    // Lock FSM, round-robin pointer, response buffer and idle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UNLOCKED;
            lock_owner <= 1'b0;
            prio       <= 1'b0;
            rsp_full   <= 1'b0;
            rsp_owner  <= 1'b0;
            rsp_result <= '0;
            rsp_jump   <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            if (accept) begin
                rsp_full   <= 1'b1;
                rsp_owner  <= grant;
                rsp_result <= alu_result_i;
                rsp_jump   <= alu_jump_now_i;
                prio       <= ~grant;
                if (state == UNLOCKED) begin
                    if (req_lock_i[grant]) begin
                        state      <= LOCKED;
                        lock_owner <= grant;
                    end
                end else if (!req_lock_i[grant]) begin
                    state <= UNLOCKED;
                end
            end else if (drain) begin
                rsp_full <= 1'b0;
            end

            // Timeout never coincides with an accept: the owner is not requesting.
            if (timeout) begin
                state <= UNLOCKED;
                prio  <= ~lock_owner;
            end

            if (!owner_idle || timeout) idle_cnt <= '0;
            else                        idle_cnt <= idle_cnt + 8'd1;
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the core's single combinational `alu` between two requesters: port 0 is the core execute stage and port 1 is the auxiliary network/debug engine. It does four things:
- grants one operation per cycle using round-robin priority;
- drives the shared ALU operands;
- registers the ALU result and branch decision into a one-entry response buffer, with valid/ready back-pressure;
- supports a lock, so one requester can keep the ALU for a multi-operation sequence, with a timeout that frees the lock.

## Interface
Parameters
- `LOCK_TIMEOUT`, default 16: consecutive idle cycles of the lock owner before the lock is forcibly released. Legal range is 1..255.

Ports
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  2  request valid, one bit per port.
- `req_ready_o`  out  2  request accepted this cycle when valid & ready.
- `req_lock_i`  in  2  sampled on accept; 1 means hold the grant after this beat.
- `req_rd_i[0:1]`  in  2x32  rd operand per port.
- `req_rs_i[0:1]`  in  2x32  rs operand per port.
- `req_op_i[0:1]`  in  2x instruction_s  instruction per port (`definitions` package).
- `alu_rd_o`, `alu_rs_o`  out  32 each  operands to the shared `alu`.
- `alu_op_o`  out  instruction_s  instruction to the shared `alu`.
- `alu_result_i`  in  32  ALU result.
- `alu_jump_now_i`  in  1  ALU branch decision.
- `resp_valid_o`  out  2  response valid for the owning port; at most one bit is set.
- `resp_ready_i`  in  2  response consumed per port.
- `resp_result_o`  out  32  registered result.
- `resp_jump_now_o`  out  1  registered branch decision.
- `locked_o`  out  1  lock state active.
- `lock_timeout_o`  out  1  one-cycle pulse when a lock times out.

## Operation
- State: `UNLOCKED` or `LOCKED`, plus `lock_owner` (1 bit), `prio` (1 bit), a response buffer (`rsp_full`, `rsp_owner`, result, jump) and an idle counter (8 bits).
- The buffer may take a new beat when `can_accept = !rsp_full | resp_ready_i[rsp_owner]`.
- Grant in `UNLOCKED`:
  - if both ports are valid, `prio` wins;
  - if one port is valid, that port wins;
  - if neither is valid, there is no grant.
- Grant in `LOCKED`: only `lock_owner` may be granted; the other port's `req_ready_o` stays 0.
- `req_ready_o[g] = grant_valid & can_accept`, where g is the granted port. Both bits are never 1 at once.
- ALU drive:
  - with a grant, `alu_*_o` carry port g's operands regardless of `can_accept`;
  - with no grant, `alu_rd_o` and `alu_rs_o` are 0 and `alu_op_o` is all-zero.
- On accept from port g (valid & ready):
  - buffer loads `alu_result_i` and `alu_jump_now_i`;
  - `rsp_owner` becomes g and `rsp_full` becomes 1;
  - `prio` becomes ~g.
- Lock transitions on accept:
  - `UNLOCKED` with `req_lock_i[g]=1` goes to `LOCKED` with `lock_owner=g`;
  - `LOCKED` with `req_lock_i[g]=0` goes to `UNLOCKED`;
  - `LOCKED` with lock=1 stays `LOCKED`.
- Idle counter:
  - resets to 0 on every cycle where `req_valid_i[lock_owner]=1`, and whenever the state is `UNLOCKED`;
  - otherwise increments while `LOCKED`.
- Timeout: when the counter reaches `LOCK_TIMEOUT`, the state goes to `UNLOCKED`, `prio` becomes ~`lock_owner`, the counter clears, and `lock_timeout_o` pulses for that one cycle.
- Response drain: when `resp_valid_o[rsp_owner] & resp_ready_i[rsp_owner]` with no new accept, `rsp_full` becomes 0.
- Simultaneous drain and accept: the buffer reloads; back-to-back throughput is 1 op per cycle.
- `resp_ready_i` of the non-owning port is ignored.
- `resp_result_o` and `resp_jump_now_o` hold their last value while the buffer is empty.
- `locked_o` is 1 exactly in `LOCKED`.

## Timing
- Reset values: state `UNLOCKED`, `prio=0`, `lock_owner=0`, `rsp_full=0`, `rsp_owner=0`, result 0, jump 0, counter 0.
- Output values while `reset` is high: `resp_valid_o=0`, `req_ready_o=0`, `locked_o=0`, `lock_timeout_o=0`.
- Reset mid-operation discards a held response and any lock. A request presented during a reset cycle is not accepted.
- Latency: a request accepted in cycle N appears on `resp_*` in cycle N+1.
- `req_ready_o` depends combinationally on `req_valid_i`, `resp_ready_i` and state. It does not depend on operand values.
- Lock release and a new grant to the other port:
  - lock released by accept in cycle N: the other port can be granted in cycle N+1;
  - lock released by timeout in cycle N: the other port can be granted in cycle N+1, not in cycle N.
- A stalled response (`resp_ready_i` low) blocks both ports. The lock timeout counter still runs during the stall.

## Test plan
- Both ports stream `kADDU` (rd=i, rs=1) with responses always ready → grants alternate 0,1,0,1 starting with port 0; each result equals rd+1 one cycle after accept; 1 op per cycle.
- Port 0 issues 3 beats with lock=1,1,0 while port 1 is continuously valid → port 1 is ready 0 for those 3 beats; `locked_o`=1 from the cycle after beat 1 until the cycle after beat 3; port 1 is granted next.
- Port 1 locks, then drops valid, with `LOCK_TIMEOUT=4` → `lock_timeout_o` pulses exactly once, 4 cycles after the last port-1 valid; port 0 is granted on the following cycle.
- `kBEQZ` with rd=0 from port 1, `resp_ready_i[1]` held low for 3 cycles → `resp_valid_o[1]`=1 and `resp_jump_now_o`=1 held stable; `req_ready_o`=0 on both ports until the drain.
- Assert `reset` while the response is full and the arbiter is `LOCKED` → next cycle `resp_valid_o`=0, `locked_o`=0, `prio`=0, and port 0 wins a simultaneous request.
